// File: rtl/weight_normalizer.sv
// weight_normalizer
//
// Divides each 8-bit lane magnitude of a packed 18-lane weight vector by a
// 9-bit norm. Each lane result is a Q0.8 fraction: q = min(255, floor(mag*256/norm)).
// One shared restoring divider handles the lanes in turn. Each lane takes
// 9 cycles: one load/saturation step and eight quotient steps.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_weights / in_norm valid
//   in_ready     high only while idle
//   in_weights   lane i = [10i+9:10i]; [10i+7:10i] magnitude, [10i+9:10i+8] flags
//   in_norm      9-bit divisor
//   out_valid    result valid, held until accepted
//   out_ready    downstream accept
//   out_weights  normalized lanes, same packing; flags pass through
//   div_by_zero  set when the accepted norm was zero (all magnitudes forced to 0)
module weight_normalizer #(
    parameter int LANES = 18,
    parameter int MAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [10*LANES-1:0]   in_weights,
    input  logic [8:0]            in_norm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_weights,
    output logic                  div_by_zero
);

    localparam int BUS_W = 10 * LANES;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state, state_next;

    logic [4:0]       lane;
    logic [3:0]       step;
    logic [BUS_W-1:0] weights;
    logic [8:0]       norm;
    logic [9:0]       rem;
    logic [MAG_W-1:0] quo;
    logic             sat;

    logic             accept;
    logic             xfer;
    logic             last_step;
    logic             last_lane;
    logic [7:0]       base;
    logic [MAG_W-1:0] cur_mag;
    logic [1:0]       cur_flags;
    logic [9:0]       rem_shift;
    logic             take;
    logic [9:0]       rem_next;
    logic [MAG_W-1:0] quo_next;

    // Zero every magnitude field, keep the flag bits.
    function automatic logic [BUS_W-1:0] clear_mags(input logic [BUS_W-1:0] w);
        clear_mags = w;
        for (int i = 0; i < LANES; i++) begin
            clear_mags[i*10 +: MAG_W] = '0;
        end
    endfunction

    // Saturated lane result: a magnitude >= norm would need quotient >= 256.
    function automatic logic [MAG_W-1:0] sat_q(input logic s, input logic [MAG_W-1:0] q);
        sat_q = s ? {MAG_W{1'b1}} : q;
    endfunction

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_step = (step == 4'd8);
    assign last_lane = (lane == 5'(LANES - 1));
    assign base      = 8'(lane) * 8'd10;
    assign cur_mag   = weights[base +: MAG_W];
    assign cur_flags = weights[base + 8'd8 +: 2];

    // One restoring-division step. rem stays below norm for non-saturated
    // lanes, so the shifted remainder fits in 10 bits. Saturated lanes may
    // wrap, which does not matter because their quotient is discarded.
    assign rem_shift = {rem[8:0], 1'b0};
    assign take      = (rem_shift >= {1'b0, norm});
    assign rem_next  = take ? (rem_shift - {1'b0, norm}) : rem_shift;
    assign quo_next  = {quo[MAG_W-2:0], take};

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (in_norm == 9'd0) ? DONE : DIV;
                end
            end
            DIV: begin
                if (last_step && last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- output decode ----
    always_comb begin
        in_ready = (state == IDLE);
    end

    // ---- lane / step counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            step <= '0;
        end else if (accept) begin
            lane <= '0;
            step <= '0;
        end else if (state == DIV) begin
            if (last_step) begin
                step <= '0;
                lane <= last_lane ? 5'd0 : lane + 5'd1;
            end else begin
                step <= step + 4'd1;
            end
        end
    end

    // ---- divider datapath ----
    always_ff @(posedge clk) begin
        if (accept) begin
            weights <= in_weights;
            norm    <= in_norm;
        end
        if (state == DIV) begin
            if (step == 4'd0) begin
                rem <= {2'b00, cur_mag};
                sat <= ({1'b0, cur_mag} >= norm);
                quo <= '0;
            end else begin
                rem <= rem_next;
                quo <= quo_next;
            end
        end
    end

    // ---- result registers ----
    // out_valid rises one edge after DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_weights <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b0;
            end else if (state == DONE) begin
                out_valid <= 1'b1;
            end

            if (accept) begin
                div_by_zero <= (in_norm == 9'd0);
                if (in_norm == 9'd0) begin
                    out_weights <= clear_mags(in_weights);
                end
            end else if (state == DIV && last_step) begin
                // A lane is written only once its quotient is complete.
                out_weights[base +: 10] <= {cur_flags, sat_q(sat, quo_next)};
            end
        end
    end

endmodule
